// File: rtl/counter_ud_mod_if.sv
// Control and status bundle for the up/down modulo counter.
// The master side (bench or upstream logic) drives the controls; the
// counter itself sits on the slave side and returns count, carry and done.
interface counter_ud_mod_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] mod_val;
  logic             one_shot;
  logic [WIDTH-1:0] q;
  logic             co;
  logic             done;

  modport master (
    output en, up, load, d, mod_val, one_shot,
    input  q, co, done
  );

  modport slave (
    input  en, up, load, d, mod_val, one_shot,
    output q, co, done
  );
endinterface

// File: rtl/counter_ud_mod.sv
// Up/down modulo counter with runtime modulus, parallel load and
// wrap / one-shot mode. Stages cascade by feeding one stage's co into
// the next stage's en. WIDTH is intended to stay within 2..16.
module counter_ud_mod #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             r,
  counter_ud_mod_if.slave bus
);

  localparam logic [0:0]       S_RUN  = 1'b0;
  localparam logic [0:0]       S_HALT = 1'b1;
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO   = '0;

  logic [WIDTH-1:0] r_q;
  logic [0:0]       r_state;
  logic             r_done;

  logic [WIDTH-1:0] w_term;
  logic             w_tc;
  logic             w_run;
  logic             w_step;
  logic [WIDTH-1:0] w_qNext;
  logic [0:0]       w_stateNext;
  logic             w_doneNext;

  // Terminal value wraps naturally, so a modulus of 0 yields all ones (full range).
  assign w_term = bus.mod_val - ONE;

  // Up uses >= so that lowering the modulus below the current count still wraps.
  assign w_tc   = bus.up ? (r_q >= w_term) : (r_q == ZERO);
  assign w_run  = (r_state == S_RUN);
  assign w_step = bus.en & ~bus.load & w_run;

  // Next-state selection: load beats counting, counting beats hold.
  always_comb begin
    w_qNext     = r_q;
    w_stateNext = r_state;
    w_doneNext  = r_done;
    if (bus.load) begin
      w_qNext     = bus.d;
      w_stateNext = S_RUN;
      w_doneNext  = 1'b0;
    end else if (w_step) begin
      if (!w_tc) begin
        if (bus.up) begin
          w_qNext = r_q + ONE;
        end else if (r_q > w_term) begin
          w_qNext = w_term;
        end else begin
          w_qNext = r_q - ONE;
        end
      end else if (bus.one_shot) begin
        w_stateNext = S_HALT;
        w_doneNext  = 1'b1;
      end else begin
        w_qNext = bus.up ? ZERO : w_term;
      end
    end
  end

  // State registers with asynchronous return to zero / RUN.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_q     <= ZERO;
      r_state <= S_RUN;
      r_done  <= 1'b0;
    end else begin
      r_q     <= w_qNext;
      r_state <= w_stateNext;
      r_done  <= w_doneNext;
    end
  end

  // Carry is combinational so the next stage steps on the same edge as this wrap.
  assign bus.co   = w_step & ~r & w_tc;
  assign bus.q    = r_q;
  assign bus.done = r_done;

endmodule

// File: tb/tb_counter_ud_mod.sv
// Self-checking bench for counter_ud_mod: directed scenarios, randomized
// traffic against an integer reference model, and a two-stage decade cascade.
module tb_counter_ud_mod;

  localparam int W    = 8;
  localparam int FULL = 1 << W;

  logic clk;
  logic r;
  logic rC;

  int checks;
  int errors;

  int mq;
  bit mHalt;

  counter_ud_mod_if #(.WIDTH(W)) busA ();
  counter_ud_mod_if #(.WIDTH(W)) busLo ();
  counter_ud_mod_if #(.WIDTH(W)) busHi ();

  counter_ud_mod #(.WIDTH(W)) dut   (.clk(clk), .r(r),  .bus(busA));
  counter_ud_mod #(.WIDTH(W)) dutLo (.clk(clk), .r(rC), .bus(busLo));
  counter_ud_mod #(.WIDTH(W)) dutHi (.clk(clk), .r(rC), .bus(busHi));

  assign busHi.en = busLo.co;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  function automatic int termOf(input int modVal);
    int m;
    m = (modVal == 0) ? FULL : modVal;
    return m - 1;
  endfunction

  function automatic bit modelTc();
    int t;
    t = termOf(int'(busA.mod_val));
    return busA.up ? (mq >= t) : (mq == 0);
  endfunction

  function automatic bit modelCo();
    return busA.en && !busA.load && !r && !mHalt && modelTc();
  endfunction

  // Advance the reference model by one clock edge using the current inputs.
  task automatic modelStep();
    int t;
    t = termOf(int'(busA.mod_val));
    if (busA.load) begin
      mq    = int'(busA.d);
      mHalt = 1'b0;
    end else if (busA.en && !mHalt) begin
      if (!modelTc()) begin
        if (busA.up) mq = mq + 1;
        else if (mq > t) mq = t;
        else mq = mq - 1;
      end else if (busA.one_shot) begin
        mHalt = 1'b1;
      end else begin
        mq = busA.up ? 0 : t;
      end
    end
  endtask

  task automatic applyStimulus(input bit en, input bit up, input bit load,
                               input int d, input int modVal, input bit oneShot);
    busA.en       = en;
    busA.up       = up;
    busA.load     = load;
    busA.d        = W'(d);
    busA.mod_val  = W'(modVal);
    busA.one_shot = oneShot;
  endtask

  // Check outputs mid-cycle, then step model and DUT across one edge.
  task automatic cycleCheck(input string tag);
    #3;
    checkOutput({tag, "_q"},    int'(busA.q),    mq);
    checkOutput({tag, "_done"}, int'(busA.done), int'(mHalt));
    checkOutput({tag, "_co"},   int'(busA.co),   int'(modelCo()));
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input string tag);
    r = 1'b1;
    #2;
    checkOutput({tag, "_rst_q"},    int'(busA.q),    0);
    checkOutput({tag, "_rst_done"}, int'(busA.done), 0);
    checkOutput({tag, "_rst_co"},   int'(busA.co),   0);
    mq    = 0;
    mHalt = 1'b0;
    @(posedge clk);
    #1;
    r = 1'b0;
  endtask

  initial begin
    int guard;
    int expLo;
    int expHi;
    checks = 0;
    errors = 0;
    r  = 1'b1;
    rC = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 5, 1'b0);
    busLo.en = 1'b1; busLo.up = 1'b1; busLo.load = 1'b0;
    busLo.d = '0; busLo.mod_val = W'(10); busLo.one_shot = 1'b0;
    busHi.up = 1'b1; busHi.load = 1'b0;
    busHi.d = '0; busHi.mod_val = W'(10); busHi.one_shot = 1'b0;
    @(posedge clk);
    #1;

    // Up count modulo 5: 0,1,2,3,4,0,1
    applyReset("up");
    for (int i = 0; i < 7; i++) cycleCheck("up_seq");
    checkOutput("up_seq_end", int'(busA.q), 2);

    // Asynchronous reset mid-cycle with q=3
    guard = 0;
    while (mq != 3 && guard < 10) begin
      cycleCheck("up_to3");
      guard++;
    end
    checkOutput("reach_q3", mq, 3);
    #2;
    r = 1'b1;
    #1;
    checkOutput("async_q",  int'(busA.q),  0);
    checkOutput("async_co", int'(busA.co), 0);
    mq = 0;
    mHalt = 1'b0;
    @(posedge clk);
    #1;
    r = 1'b0;

    // Down count with wrap: 0,4,3,2,1,0,4
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 5, 1'b0);
    applyReset("down");
    for (int i = 0; i < 7; i++) cycleCheck("down_seq");
    checkOutput("down_seq_end", int'(busA.q), 3);

    // One-shot: load 2, mod 4 -> 2,3,3,3 with done sticky
    applyStimulus(1'b1, 1'b1, 1'b1, 2, 4, 1'b1);
    cycleCheck("os_load");
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 4, 1'b1);
    for (int i = 0; i < 5; i++) cycleCheck("os_run");
    checkOutput("os_done_held", int'(busA.done), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 0, 4, 1'b1);
    cycleCheck("os_reload");
    checkOutput("os_reload_q",    int'(busA.q),    0);
    checkOutput("os_reload_done", int'(busA.done), 0);

    // Modulus 0 means full range: 254,255,0
    applyStimulus(1'b0, 1'b1, 1'b1, 254, 0, 1'b0);
    cycleCheck("m0_load");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) cycleCheck("m0_seq");

    // Modulus lowered below the count: down clamps to 9, up wraps to 0
    applyStimulus(1'b0, 1'b0, 1'b1, 200, 0, 1'b0);
    cycleCheck("shrink_load_dn");
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 10, 1'b0);
    cycleCheck("shrink_dn");
    checkOutput("shrink_dn_q", int'(busA.q), 9);
    applyStimulus(1'b0, 1'b1, 1'b1, 200, 0, 1'b0);
    cycleCheck("shrink_load_up");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 10, 1'b0);
    cycleCheck("shrink_up");
    checkOutput("shrink_up_q", int'(busA.q), 0);

    // Load and enable together at terminal count; then enable low at terminal
    applyStimulus(1'b0, 1'b1, 1'b1, 4, 5, 1'b0);
    cycleCheck("sim_setT");
    applyStimulus(1'b1, 1'b1, 1'b1, 7, 5, 1'b0);
    cycleCheck("sim_loaden");
    checkOutput("sim_loaden_q", int'(busA.q), 7);
    applyStimulus(1'b0, 1'b1, 1'b1, 4, 5, 1'b0);
    cycleCheck("sim_setT2");
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 5, 1'b0);
    cycleCheck("sim_enlow");
    checkOutput("sim_enlow_q", int'(busA.q), 4);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        applyReset("rnd");
      end else begin
        applyStimulus(
          ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FULL - 1)) : int'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FULL - 1)) : int'($urandom_range(0, 12)),
          ($urandom_range(0, 3) == 0));
        cycleCheck("rnd");
      end
    end

    // Two-stage decade cascade: combined value 00..99 then back to 00
    #2;
    rC = 1'b1;
    @(posedge clk);
    #1;
    rC = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      #3;
      expLo = k % 10;
      expHi = (k / 10) % 10;
      checkOutput("casc_val", int'(busHi.q) * 10 + int'(busLo.q), expHi * 10 + expLo);
      checkOutput("casc_lo_co", int'(busLo.co), int'(expLo == 9));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ud_mod.md
# counter_ud_mod

Parametrised up/down modulo counter with runtime-selectable modulus, parallel load, and wrap or one-shot mode. It is the general-purpose successor to the fixed-modulus enable counter. Use it for clock-enable dividers, note-duration timers and tone-period generators in the music player datapath. Carry-out is cascadable exactly as before: drive the next stage's `en` from this stage's `co`.

## Interface
Parameters:
- `WIDTH`, 8: counter state width in bits; legal range 2–16.

Ports:
- `clk`, in, 1: clock; all state changes on its rising edge.
- `r`, in, 1: reset; asynchronous, active-high.
- `en`, in, 1: count enable; one step per enabled cycle.
- `up`, in, 1: direction; 1 = up, 0 = down.
- `load`, in, 1: synchronous parallel load of `d`.
- `d`, in, WIDTH: load value.
- `mod_val`, in, WIDTH: runtime modulus M; count range is 0..M-1; 0 means M = 2^WIDTH.
- `one_shot`, in, 1: 1 = halt at terminal count; 0 = wrap.
- `q`, out, WIDTH: current count (registered).
- `co`, out, 1: carry/borrow pulse (combinational).
- `done`, out, 1: one-shot completion flag (registered, sticky).

## Operation
- Terminal value: T = `mod_val` - 1, computed in WIDTH-bit wrap arithmetic, so `mod_val`=0 gives T = all ones.
- Terminal condition `tc`:
  - up: `q` >= T. The `>=` ensures a modulus lowered below `q` still wraps.
  - down: `q` == 0.
- FSM has two states:
  - RUN: counting allowed; reset state.
  - HALT: `q` frozen, `done`=1.
- Per-edge priority (after async reset): `load` > count > hold.
  - `load`=1: `q` <= `d`, state <= RUN, `done` <= 0. No count step that cycle, regardless of `en`.
  - `load`=0, `en`=1, RUN, `tc`=0:
    - up: `q` <= `q`+1.
    - down: if `q` > T then `q` <= T (clamp after modulus reduction), else `q` <= `q`-1.
  - `load`=0, `en`=1, RUN, `tc`=1:
    - `one_shot`=0: wrap. Up gives `q` <= 0; down gives `q` <= T.
    - `one_shot`=1: `q` holds, state <= HALT, `done` <= 1.
  - HALT: `q` holds regardless of `en`, `up` and `mod_val`. Exit only via `load` or `r`.
  - `en`=0: hold.
- `co` = `en` & ~`load` & ~`r` & RUN & `tc`.
  - Asserted in the cycle of the wrap or halt transition only.
  - Never asserted while in HALT.
- `load` of `d` >= `mod_val` (nonzero `mod_val`) is accepted as-is.
  - Up: the next enabled step wraps to 0 (tc true), asserting `co`.
  - Down: the next step clamps to T, with no `co`.
- `up`, `mod_val` and `one_shot` may change on any cycle; they take effect at the next edge.

## Timing
- Reset (`r`=1, asynchronous, independent of `clk`): `q`=0, `done`=0, state RUN, `co`=0 immediately.
  - Release is synchronous to the next rising edge; the first count can occur on the first edge with `r`=0.
- `q` and `done` update one edge after the qualifying inputs.
- `co` is combinational from the current `q`, `en`, `up`, `mod_val`, `load` and `r`; there is no added latency.
- Cascade: stage k+1 `en` = stage k `co`. Stage k+1 steps on the same edge that stage k wraps.
- Reset mid-count or in HALT: immediate return to `q`=0, RUN, `done`=0.
- `load` and `en` in the same cycle: load wins, `co`=0.
- Wrap period with constant `en`=1 and `one_shot`=0 is exactly M cycles; `co` is high for 1 of every M cycles.

## Test plan
- Reset, then up count: WIDTH=8, `mod_val`=5, `up`=1, `en`=1, `one_shot`=0.
  - `q` sequence is 0,1,2,3,4,0,1.
  - `co`=1 only while `q`=4.
  - Asserting `r` asynchronously mid-cycle with `q`=3 forces `q`=0 and `co`=0 before the next edge.
- Down count with wrap: `mod_val`=5, `up`=0, `en`=1 from reset.
  - `q` sequence is 0,4,3,2,1,0,4.
  - `co`=1 while `q`=0 and `en`=1.
- One-shot: `load` `d`=2, `mod_val`=4, `up`=1, `one_shot`=1, `en`=1.
  - `q` sequence is 2,3,3,3…
  - `co`=1 for exactly one cycle (`q`=3).
  - `done` rises one edge after that and stays 1 with `en`=1.
  - Then `load` `d`=0 gives `q`=0 and `done`=0 next edge.
- Modulus 0 and modulus change:
  - `mod_val`=0, WIDTH=8, `q` loaded with 254: sequence 254,255,0; `co` at 255.
  - Then `mod_val`=10 with `q`=200, `up`=0: next `q`=9.
  - With `up`=1 instead: next `q`=0 and `co`=1.
- Simultaneous events:
  - `load`=1, `en`=1, `q`=T, `d`=7: `q`=7 next edge, `co`=0.
  - `en`=0 at `q`=T: `co`=0 and `q` holds.
- Cascade of two instances (`mod_val`=10 each, `en`=1): the high stage advances once every 10 cycles, and the combined value reads 00→99→00 in 100 cycles.
